// File: rtl/rs_dec_msg_framer.sv
// RS decoder message framer: strips parity, re-frames the K message symbols with sop/eop
// into a first-word-fall-through FIFO. Optional statistics counters: `define RS_FRAMER_STATS_EN.
module rs_dec_msg_framer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sym_width,
  input  logic        symb_out_val,
  input  logic [7:0]  symb_out_cnt,
  input  logic [7:0]  symb_corrected,
  input  logic        dout_ready,
  output logic        dout_val,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_err,
  output logic [7:0]  dout,
  output logic        ovf,
  output logic        seq_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       err;
    logic [7:0] data;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    PARITY
  } state_t;

  localparam ent_t ABORT_ENT = '{sop: 1'b0, eop: 1'b1, err: 1'b1, data: 8'h00};

  function automatic logic [7:0] cw_len(input logic [3:0] w);
    case (w)
      4'd3:    return 8'd7;
      4'd4:    return 8'd15;
      4'd5:    return 8'd31;
      4'd6:    return 8'd63;
      4'd7:    return 8'd127;
      4'd8:    return 8'd255;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] par_len(input logic [3:0] w);
    case (w)
      4'd3, 4'd4: return 8'd4;
      4'd5, 4'd6: return 8'd8;
      4'd7:       return 8'd16;
      4'd8:       return 8'd32;
      default:    return 8'd0;
    endcase
  endfunction

  state_t      state, state_n;
  logic [3:0]  w_lat;
  logic [7:0]  exp_idx, exp_n;
  logic [7:0]  k_last, n_last;
  logic        width_ok, is_last, start, seq_set;
  ent_t        sop_ent, e0, e1;
  logic        e0_v, e1_v;

  logic        hold_v, hold_v_n, pend, pend_n, ferr, ferr_n;
  ent_t        hold_q, hold_n;
  ent_t [2:0]  lst;
  logic [2:0]  lst_v, drop_sel;
  logic [1:0]  ndrop;
  logic        push;
  ent_t        push_ent;

  logic [AW:0] wr_ptr, rd_ptr;
  ent_t        mem [DEPTH];
  ent_t        head;
  logic        empty, full, pop, space;

  assign width_ok = (sym_width >= 4'd3) && (sym_width <= 4'd8);
  assign k_last   = cw_len(w_lat) - par_len(w_lat) - 8'd1;
  assign n_last   = cw_len(w_lat) - 8'd1;
  assign is_last  = (symb_out_cnt == k_last);
  assign sop_ent  = '{sop: 1'b1, eop: 1'b0, err: 1'b0, data: symb_corrected};

  // Decide which entries (at most two: abort then new sop) the current beat produces
  always_comb begin
    state_n = state;
    exp_n   = exp_idx;
    start   = 1'b0;
    seq_set = 1'b0;
    e0_v    = 1'b0;
    e0      = '0;
    e1_v    = 1'b0;
    e1      = '0;
    case (state)
      IDLE: begin
        if (symb_out_val && symb_out_cnt == 8'd0 && width_ok) begin
          e0_v  = 1'b1;
          e0    = sop_ent;
          start = 1'b1;
        end
      end
      MSG: begin
        if (symb_out_val) begin
          if (symb_out_cnt == exp_idx) begin
            e0_v  = 1'b1;
            e0    = '{sop: 1'b0, eop: is_last, err: 1'b0, data: symb_corrected};
            exp_n = exp_idx + 8'd1;
            if (is_last) state_n = PARITY;
          end else begin
            seq_set = 1'b1;
            e0_v    = 1'b1;
            e0      = ABORT_ENT;
            if (symb_out_cnt == 8'd0 && width_ok) begin
              e1_v  = 1'b1;
              e1    = sop_ent;
              start = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      PARITY: begin
        if (symb_out_val) begin
          if (symb_out_cnt == 8'd0) begin
            seq_set = 1'b1;
            if (width_ok) begin
              e0_v  = 1'b1;
              e0    = sop_ent;
              start = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else if (symb_out_cnt == n_last) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (start) begin
      state_n = MSG;
      exp_n   = 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      w_lat   <= '0;
      exp_idx <= '0;
      seq_err <= 1'b0;
    end else begin
      state   <= state_n;
      exp_idx <= exp_n;
      if (start) w_lat <= sym_width;
      if (seq_set) seq_err <= 1'b1;
    end
  end

  // Oldest-first list of candidates: the skid entry, then this cycle's new entries
  always_comb begin
    lst   = '0;
    lst_v = '0;
    if (hold_v) begin
      lst[0]   = hold_q;
      lst_v[0] = 1'b1;
      lst[1]   = e0;
      lst_v[1] = e0_v;
      lst[2]   = e1;
      lst_v[2] = e1_v;
    end else begin
      lst[0]   = e0;
      lst_v[0] = e0_v;
      lst[1]   = e1;
      lst_v[1] = e1_v;
    end
  end

  // A pending eop owns the write slot and everything younger is lost; otherwise the oldest
  // candidate takes the slot, the next waits in the hold register, and any third is lost.
  always_comb begin
    push     = 1'b0;
    push_ent = '0;
    hold_v_n = 1'b0;
    hold_n   = hold_q;
    pend_n   = pend;
    ferr_n   = ferr;
    ndrop    = 2'd0;
    drop_sel = '0;
    if (pend) begin
      if (space) begin
        push     = 1'b1;
        push_ent = ABORT_ENT;
        pend_n   = 1'b0;
      end
      drop_sel = lst_v;
    end else begin
      if (lst_v[0]) begin
        if (space) begin
          push     = 1'b1;
          push_ent = lst[0];
          if (lst[0].eop) begin
            push_ent.err = lst[0].err | ferr;
            ferr_n       = 1'b0;
          end
        end else begin
          drop_sel[0] = 1'b1;
        end
      end
      hold_v_n    = lst_v[1];
      hold_n      = lst[1];
      drop_sel[2] = lst_v[2];
    end
    for (int i = 0; i < 3; i++) begin
      if (drop_sel[i]) begin
        ndrop = ndrop + 2'd1;
        if (lst[i].eop) begin
          pend_n = 1'b1;
          ferr_n = 1'b0;
        end else begin
          ferr_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
      hold_q <= '0;
      pend   <= 1'b0;
      ferr   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      hold_v <= hold_v_n;
      hold_q <= hold_n;
      pend   <= pend_n;
      ferr   <= ferr_n;
      if (ndrop != 2'd0) ovf <= 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && dout_ready;
  assign space = !full || pop;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Memory is not reset, so mask the head while empty to keep outputs at zero
  always_comb begin
    dout_val = !empty;
    dout_sop = !empty && head.sop;
    dout_eop = !empty && head.eop;
    dout_err = !empty && head.err;
    dout     = empty ? 8'h00 : head.data;
  end

`ifdef RS_FRAMER_STATS_EN
  logic [15:0] frame_q, drop_q;
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_q} + {15'd0, ndrop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      if (pop && head.eop && frame_q != 16'hFFFF) frame_q <= frame_q + 16'd1;
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;
`else
  assign frame_cnt = 16'd0;
  assign drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_rs_dec_msg_framer.sv
// Randomized + directed bench for rs_dec_msg_framer against a queue-based behavioural model.
module tb_rs_dec_msg_framer;
  localparam int DEPTH = 16;
`ifdef RS_FRAMER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sym_width = 4'd0;
  logic        symb_out_val = 1'b0;
  logic [7:0]  symb_out_cnt = 8'd0;
  logic [7:0]  symb_corrected = 8'd0;
  logic        dout_ready = 1'b0;
  logic        dout_val, dout_sop, dout_eop, dout_err, ovf, seq_err;
  logic [7:0]  dout;
  logic [15:0] frame_cnt, drop_cnt;

  rs_dec_msg_framer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sym_width(sym_width), .symb_out_val(symb_out_val),
    .symb_out_cnt(symb_out_cnt), .symb_corrected(symb_corrected), .dout_ready(dout_ready),
    .dout_val(dout_val), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_err(dout_err),
    .dout(dout), .ovf(ovf), .seq_err(seq_err), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: entries are {sop, eop, err, data}; phase 0 = waiting for frame, 1 = message, 2 = parity
  int m_ph, m_w, m_exp, m_frames, m_drops;
  bit m_seq, m_ovf, m_ferr, m_pend;
  logic [10:0] mfifo[$];
  logic [10:0] pre[$];
  logic [10:0] got[$];

  function automatic int nn(int w);
    return (1 << w) - 1;
  endfunction

  function automatic int rr(int w);
    case (w)
      3, 4:    return 4;
      5, 6:    return 8;
      7:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [10:0] got_at(int i);
    if (i < got.size()) return got[i];
    return 11'bx;
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_w = 0; m_exp = 0; m_frames = 0; m_drops = 0;
    m_seq = 0; m_ovf = 0; m_ferr = 0; m_pend = 0;
    mfifo.delete();
    pre.delete();
  endtask

  task automatic m_drop(logic [10:0] e);
    m_ovf = 1;
    if (m_drops < 65535) m_drops++;
    if (e[9]) begin
      m_pend = 1;
      m_ferr = 0;
    end else begin
      m_ferr = 1;
    end
  endtask

  task automatic model_step(bit v, int c, int d, int w, bit r);
    logic [10:0] gen[$];
    logic [10:0] lst[$];
    logic [10:0] e;
    bit ok, start;
    ok = (w >= 3 && w <= 8);
    start = 0;
    if (v) begin
      if (m_ph == 0) begin
        start = (c == 0 && ok);
      end else if (m_ph == 1) begin
        if (c == m_exp) begin
          gen.push_back({1'b0, c == nn(m_w) - rr(m_w) - 1, 1'b0, d[7:0]});
          if (c == nn(m_w) - rr(m_w) - 1) m_ph = 2;
          m_exp++;
        end else begin
          m_seq = 1;
          gen.push_back(11'h300);
          if (c == 0 && ok) start = 1;
          else m_ph = 0;
        end
      end else begin
        if (c == 0) begin
          m_seq = 1;
          if (ok) start = 1;
          else m_ph = 0;
        end else if (c == nn(m_w) - 1) begin
          m_ph = 0;
        end
      end
    end
    if (start) begin
      gen.push_back({3'b100, d[7:0]});
      m_w = w; m_exp = 1; m_ph = 1;
    end
    if (mfifo.size() != 0 && r) begin
      e = mfifo.pop_front();
      if (e[9] && m_frames < 65535) m_frames++;
    end
    lst = pre;
    foreach (gen[i]) lst.push_back(gen[i]);
    pre.delete();
    if (m_pend) begin
      if (mfifo.size() < DEPTH) begin
        mfifo.push_back(11'h300);
        m_pend = 0;
      end
      foreach (lst[i]) m_drop(lst[i]);
    end else if (lst.size() != 0) begin
      e = lst.pop_front();
      if (mfifo.size() < DEPTH) begin
        if (e[9]) begin
          e[8] = e[8] | m_ferr;
          m_ferr = 0;
        end
        mfifo.push_back(e);
      end else begin
        m_drop(e);
      end
      if (lst.size() != 0) pre.push_back(lst.pop_front());
      foreach (lst[i]) m_drop(lst[i]);
    end
  endtask

  // Per-cycle comparison of every output against the model, plus capture of popped beats
  always @(negedge clk) begin
    logic [11:0] exp_beat;
    exp_beat = (mfifo.size() != 0) ? {1'b1, mfifo[0]} : 12'h000;
    check_output("beat", {52'd0, dout_val, dout_sop, dout_eop, dout_err, dout}, {52'd0, exp_beat});
    check_output("flags", {30'd0, ovf, seq_err, frame_cnt, drop_cnt},
                 {30'd0, m_ovf, m_seq, STATS_ON ? m_frames[15:0] : 16'd0,
                  STATS_ON ? m_drops[15:0] : 16'd0});
    if (dout_val && dout_ready) got.push_back({dout_sop, dout_eop, dout_err, dout});
  end

  task automatic apply_stimulus(bit v, int c, int d, int w, bit r);
    symb_out_val   = v;
    symb_out_cnt   = c[7:0];
    symb_corrected = d[7:0];
    sym_width      = w[3:0];
    dout_ready     = r;
    @(posedge clk);
    model_step(v, c, d, w, r);
    #1;
  endtask

  task automatic do_reset();
    symb_out_val = 1'b0;
    dout_ready   = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got.delete();
  endtask

  task automatic idle_cycles(int n, bit r);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 4, r);
  endtask

  initial begin
    int w, n, len, c, ws, rmode;
    bit rdy;
    model_reset();
    do_reset();
    check_output("reset_val", {63'd0, dout_val}, 64'd0);
    check_output("reset_flags", {46'd0, ovf, seq_err, frame_cnt}, 64'd0);

    // Width 4 frame, ready high
    for (int i = 0; i < 15; i++) apply_stimulus(1, i, i, 4, 1);
    idle_cycles(10, 1);
    check_output("t1_len", got.size(), 11);
    for (int i = 0; i < 11; i++)
      check_output("t1_beat", got_at(i), {i == 0, i == 10, 1'b0, i[7:0]});
    check_output("t1_model_frames", m_frames, 1);
    check_output("t1_frame_cnt", frame_cnt, STATS_ON ? 16'd1 : 16'd0);

    // Width 8 frame into a stalled sink
    do_reset();
    for (int i = 0; i < 300; i++) apply_stimulus(i < 255, i < 255 ? i : 0, i < 255 ? i : 0, 8, 0);
    check_output("t2_model_drops", m_drops, 207);
    check_output("t2_drop_cnt", drop_cnt, STATS_ON ? 16'd207 : 16'd0);
    check_output("t2_ovf", ovf, 1);
    idle_cycles(40, 1);
    check_output("t2_len", got.size(), 17);
    check_output("t2_first", got_at(0), 11'h400);
    check_output("t2_last_data", got_at(15), 11'h00F);
    check_output("t2_eop", got_at(16), 11'h300);

    // Index discontinuity
    do_reset();
    apply_stimulus(1, 0, 0, 5, 1);
    apply_stimulus(1, 1, 1, 5, 1);
    apply_stimulus(1, 2, 2, 5, 1);
    apply_stimulus(1, 5, 5, 5, 1);
    for (int i = 6; i < 31; i++) apply_stimulus(1, i, i, 5, 1);
    idle_cycles(5, 1);
    check_output("t3_len", got.size(), 4);
    check_output("t3_b2", got_at(2), 11'h002);
    check_output("t3_abort", got_at(3), 11'h300);
    check_output("t3_seq_err", seq_err, 1);

    // Width change mid-frame is ignored until the next frame
    do_reset();
    for (int i = 0; i < 63; i++) apply_stimulus(1, i, i, i < 10 ? 6 : 3, 1);
    for (int i = 0; i < 7; i++) apply_stimulus(1, i, i, 3, 1);
    idle_cycles(5, 1);
    check_output("t4_len", got.size(), 58);
    check_output("t4_eop1", got_at(54), 11'h236);
    check_output("t4_sop2", got_at(55), 11'h400);
    check_output("t4_eop2", got_at(57), 11'h202);

    // Illegal width
    do_reset();
    for (int i = 0; i < 8; i++) apply_stimulus(1, i, i, 2, 1);
    idle_cycles(3, 1);
    check_output("t5_len", got.size(), 0);
    check_output("t5_flags", {62'd0, ovf, seq_err}, 64'd0);

    // Reset mid-frame
    do_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(1, i, i, 7, 0);
    do_reset();
    check_output("t6_val", {63'd0, dout_val}, 64'd0);
    for (int i = 5; i < 127; i++) apply_stimulus(1, i, i, 7, 1);
    for (int i = 0; i < 127; i++) apply_stimulus(1, i, i, 7, 1);
    idle_cycles(5, 1);
    check_output("t6_len", got.size(), 111);
    check_output("t6_eop", got_at(110), 11'h26E);
    check_output("t6_flags", {62'd0, ovf, seq_err}, 64'd0);

    // Randomized codewords with gaps, glitches, truncation, width changes and back-pressure
    do_reset();
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) == 0) w = ($urandom_range(0, 1) == 0) ? 2 : 9;
      else w = $urandom_range(3, 8);
      n = (w >= 3 && w <= 8) ? nn(w) : 15;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, n) : n;
      rmode = $urandom_range(0, 2);
      for (int i = 0; i < len; i++) begin
        rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 1) == 1)
                                                 : ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0)
          apply_stimulus(0, $urandom_range(0, 255), $urandom_range(0, 255), w, rdy);
        c = ($urandom_range(0, 49) == 0) ? $urandom_range(0, n - 1) : i;
        ws = (i != 0 && $urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : w;
        apply_stimulus(1, c, $urandom_range(0, 255) & n, ws, rdy);
      end
    end
    idle_cycles(300, 1);
    check_output("rand_drained", {63'd0, dout_val}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
